fifo_sync_lvl: RTL and testbench
================================

// Module: fifo_sync_lvl
// PURPOSE
//  Parametrised synchronous circular FIFO, successor to the per-block FIFO used in the audio/PCM paths.
//  Pointer and flag logic is fully clocked, so there are no edge-triggered control paths.
//  Adds an occupancy count, programmable almost-full/almost-empty levels and sticky overflow/underflow errors.
//  Sits between producers such as the microphone PCM deserialiser and consumers such as the bus or audio out.
// PARAMETERS
//  ADR_WIDTH  4   address bits; DEPTH = 2**ADR_WIDTH entries, all usable
//  DAT_WIDTH  18  data word width
//  AF_LEVEL   12  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL   2   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk           in   1            single clock; everything samples on posedge
//  reset         in   1            asynchronous, active-high
//  wr            in   1            write request, level-sampled each clk
//  rd            in   1            read request, level-sampled each clk
//  data_in       in   DAT_WIDTH    write data
//  clr_err       in   1            synchronous clear of overflow/underflow
//  data_out      out  DAT_WIDTH    read data (timing per CONFIGURATION)
//  empty         out  1            count == 0
//  full          out  1            count == DEPTH
//  almost_empty  out  1            count <= AE_LEVEL
//  almost_full   out  1            count >= AF_LEVEL
//  count         out  ADR_WIDTH+1  occupancy, 0..DEPTH
//  overflow      out  1            sticky: a wr was refused
//  underflow     out  1            sticky: a rd was refused
// BEHAVIOUR
//  - Reset (async): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0.
//    Storage array is not reset.
//  - Acceptance, evaluated each clk from current registered state:
//    wr_ok = wr & (~full | rd_ok)
//    rd_ok = rd & ~empty
//  - wr_ok: array[w_ptr] <= data_in; w_ptr += 1, wrapping DEPTH-1 -> 0.
//  - rd_ok: r_ptr += 1, wrapping.
//  - count: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
//  - Flags are derived from the next count and registered, so they are valid the cycle after the access.
//    No combinational path from wr/rd to any flag.
//  - Full and wr&rd together: both are accepted. The new word overwrites the slot being read only after the read.
//    count stays DEPTH and full stays 1.
//  - Empty and wr&rd together: the write is accepted and the read is refused.
//    count becomes 1; underflow sets.
//  - Errors: overflow sets on wr & ~wr_ok; underflow sets on rd & ~rd_ok.
//    clr_err clears both in the following cycle.
//    A new error in the same cycle as clr_err wins, so the flag stays 1.
//  - Reset mid-operation discards all contents immediately. Pending rd/wr in that cycle are ignored.
//  - Data order is strictly FIFO; no word is lost or duplicated under any rd/wr pattern.
// CONFIGURATION
//  FIFO_FWFT_EN defined:
//  - first-word fall-through; data_out = array[r_ptr] combinationally
//  - head word is visible 1 cycle after the write that made the FIFO non-empty
//  - rd acts as acknowledge and pops the head
//  - data_out undefined while empty
//  FIFO_FWFT_EN undefined (default):
//  - registered output; on rd_ok, data_out <= array[r_ptr], valid the cycle after rd
//  - data_out holds its last value otherwise, including while empty
// TESTING
//  1. Reset, then write 0x00001..0x00010 on 16 consecutive cycles, no rd
//     -> count steps 1..16; almost_full rises when count reaches 12; full=1 after the 16th write.
//  2. Full, wr=1 with data 0x3FFFF, rd=0
//     -> overflow=1, count=16, contents unchanged.
//     Then pulse clr_err -> overflow=0.
//  3. Full, drain with rd for 16 cycles
//     -> data 0x00001..0x00010 in order (registered mode: each 1 cycle after rd).
//     -> empty=1 after the last rd; almost_empty=1 once count <= 2.
//  4. Empty, wr=rd=1 with data 0x0ABCD
//     -> count=1, underflow=1.
//     -> next rd returns 0x0ABCD.
//  5. Full, wr=rd=1 for 20 cycles with incrementing data
//     -> count stays 16, full stays 1.
//     -> read stream continues in order across the pointer wrap.
//  6. Reset asserted asynchronously with count=7
//     -> count=0 and empty=1 immediately, before the next clk edge.
//     Repeat tests 1-4 with FIFO_FWFT_EN defined.

Source files
------------

// File: rtl/fifo_sync_lvl.sv
// fifo_sync_lvl: synchronous circular FIFO with occupancy count, programmable
// almost-full/almost-empty levels and sticky overflow/underflow errors.
//
// Optional feature macro: FIFO_FWFT_EN
//   defined   -> first-word fall-through, data_out shows the head word directly
//   undefined -> registered output, data_out updates the cycle after an accepted rd
//
// Ports
//   clk           in   single clock, posedge
//   reset         in   asynchronous, active-high
//   wr, rd        in   write / read requests, level-sampled each clk
//   data_in       in   write data
//   clr_err       in   synchronous clear of overflow/underflow
//   data_out      out  read data
//   empty, full   out  count == 0 / count == DEPTH (registered)
//   almost_empty  out  count <= AE_LEVEL (registered)
//   almost_full   out  count >= AF_LEVEL (registered)
//   count         out  occupancy 0..DEPTH (registered)
//   overflow      out  sticky, a wr was refused
//   underflow     out  sticky, a rd was refused
module fifo_sync_lvl #(
    parameter int unsigned ADR_WIDTH = 4,
    parameter int unsigned DAT_WIDTH = 18,
    parameter int unsigned AF_LEVEL  = 12,
    parameter int unsigned AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [DAT_WIDTH-1:0] data_in,
    input  logic                 clr_err,
    output logic [DAT_WIDTH-1:0] data_out,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [ADR_WIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned DEPTH = 2 ** ADR_WIDTH;
    localparam int unsigned CW    = ADR_WIDTH + 1;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

    logic [DAT_WIDTH-1:0] r_mem [DEPTH];
    logic [ADR_WIDTH-1:0] r_wptr;
    logic [ADR_WIDTH-1:0] r_rptr;
    logic [CW-1:0]        r_count;
    logic                 r_empty;
    logic                 r_full;
    logic                 r_almost_empty;
    logic                 r_almost_full;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_rd_ok;
    logic                 w_wr_ok;
    logic [CW-1:0]        w_count_nxt;

    // Acceptance from registered state only; a read frees a slot for a write when full.
    assign w_rd_ok = rd & ~r_empty;
    assign w_wr_ok = wr & (~r_full | w_rd_ok);

    // Next occupancy; simultaneous accepted wr and rd cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Pointers, count, flags and sticky errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + ADR_WIDTH'(1);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + ADR_WIDTH'(1);
            end
            r_count        <= w_count_nxt;
            r_empty        <= (w_count_nxt == '0);
            r_full         <= (w_count_nxt == C_DEPTH);
            r_almost_empty <= (w_count_nxt <= C_AE);
            r_almost_full  <= (w_count_nxt >= C_AF);
            // A fresh error in the clearing cycle keeps the flag set.
            r_overflow     <= (r_overflow  & ~clr_err) | (wr & ~w_wr_ok);
            r_underflow    <= (r_underflow & ~clr_err) | (rd & ~w_rd_ok);
        end
    end

    // Storage is not reset. When full with wr&rd, the read of this slot sees the old word.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word presented directly; rd only acknowledges and pops it.
    assign data_out = r_mem[r_rptr];
`else
    logic [DAT_WIDTH-1:0] r_dout;

    // Registered read port; holds its value when no read is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout <= '0;
        end else if (w_rd_ok) begin
            r_dout <= r_mem[r_rptr];
        end
    end

    assign data_out = r_dout;
`endif

    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Directed testbench for fifo_sync_lvl; adapts data_out expectations to FIFO_FWFT_EN.
module tb_fifo_sync_lvl;

    logic        clk;
    logic        reset;
    logic        wr;
    logic        rd;
    logic [17:0] data_in;
    logic        clr_err;
    logic [17:0] data_out;
    logic        empty;
    logic        full;
    logic        almost_empty;
    logic        almost_full;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    fifo_sync_lvl #(
        .ADR_WIDTH (4),
        .DAT_WIDTH (18),
        .AF_LEVEL  (12),
        .AE_LEVEL  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .data_in      (data_in),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data_in = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
            errors++; $display("FAIL reset_flags got=%b exp=1010", {empty, full, almost_empty, almost_full}); end
        checks++; if ({overflow, underflow} !== 2'b00) begin
            errors++; $display("FAIL reset_errs got=%b exp=00", {overflow, underflow}); end
`ifndef FIFO_FWFT_EN
        checks++; if (data_out !== 18'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", data_out); end
`endif
    endtask

    // Test 1: 16 writes 1..16, no rd.
    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            wr = 1'b1; data_in = 18'(i);
            tick();
            checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
            checks++; if (almost_full !== (i >= 12)) begin errors++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i >= 12)); end
            checks++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 16)); end
            checks++; if (almost_empty !== (i <= 2)) begin errors++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty, (i <= 2)); end
            checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
`ifdef FIFO_FWFT_EN
            checks++; if (data_out !== 18'h1) begin errors++; $display("FAIL fill_head[%0d] got=%h exp=1", i, data_out); end
`endif
        end
        wr = 1'b0;
    endtask

    // Test 2: write while full is refused and flagged; clr_err clears.
    task automatic test_overflow();
        wr = 1'b1; data_in = 18'h3FFFF;
        tick();
        wr = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL ovf_uf got=%b exp=0", underflow); end
`ifdef FIFO_FWFT_EN
        checks++; if (data_out !== 18'h1) begin errors++; $display("FAIL ovf_head got=%h exp=1", data_out); end
`else
        checks++; if (data_out !== 18'h0) begin errors++; $display("FAIL ovf_dout got=%h exp=0", data_out); end
`endif
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    // Test 3: drain 16 words in order.
    task automatic test_drain();
        for (int k = 1; k <= 16; k++) begin
            rd = 1'b1;
`ifdef FIFO_FWFT_EN
            checks++; if (data_out !== 18'(k)) begin errors++; $display("FAIL drain_head[%0d] got=%h exp=%h", k, data_out, 18'(k)); end
`endif
            tick();
`ifndef FIFO_FWFT_EN
            checks++; if (data_out !== 18'(k)) begin errors++; $display("FAIL drain_dout[%0d] got=%h exp=%h", k, data_out, 18'(k)); end
`endif
            checks++; if (count !== 5'(16 - k)) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, count, 16 - k); end
            checks++; if (almost_empty !== ((16 - k) <= 2)) begin errors++; $display("FAIL drain_ae[%0d] got=%b exp=%b", k, almost_empty, ((16 - k) <= 2)); end
            checks++; if (empty !== (k == 16)) begin errors++; $display("FAIL drain_empty[%0d] got=%b exp=%b", k, empty, (k == 16)); end
        end
        rd = 1'b0;
        checks++; if ({overflow, underflow, full} !== 3'b000) begin
            errors++; $display("FAIL drain_errs got=%b exp=000", {overflow, underflow, full}); end
    endtask

    // Test 4: wr&rd while empty: write accepted, read refused.
    task automatic test_empty_wr_rd();
        wr = 1'b1; rd = 1'b1; data_in = 18'h0ABCD;
        tick();
        wr = 1'b0; rd = 1'b0;
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL ewr_count got=%0d exp=1", count); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL ewr_uf got=%b exp=1", underflow); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL ewr_empty got=%b exp=0", empty); end
`ifdef FIFO_FWFT_EN
        checks++; if (data_out !== 18'h0ABCD) begin errors++; $display("FAIL ewr_head got=%h exp=0abcd", data_out); end
`else
        checks++; if (data_out !== 18'h10) begin errors++; $display("FAIL ewr_hold got=%h exp=10", data_out); end
`endif
        rd = 1'b1;
        tick();
        rd = 1'b0;
`ifndef FIFO_FWFT_EN
        checks++; if (data_out !== 18'h0ABCD) begin errors++; $display("FAIL ewr_rd got=%h exp=0abcd", data_out); end
`endif
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL ewr_after count=%0d empty=%b exp 0/1", count, empty); end
        // Clear with a new underflow in the same cycle: flag stays set.
        clr_err = 1'b1; rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_clr_race got=%b exp=1", underflow); end
        tick();
        clr_err = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clr got=%b exp=0", underflow); end
    endtask

    // Test 5: full with wr&rd for 20 cycles; order holds across pointer wrap.
    task automatic test_back_to_back();
        logic [17:0] exp_d;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; data_in = 18'h00100 + 18'(i);
            tick();
        end
        for (int j = 0; j < 20; j++) begin
            exp_d = (j < 16) ? (18'h00100 + 18'(j)) : (18'h00200 + 18'(j - 16));
            wr = 1'b1; rd = 1'b1; data_in = 18'h00200 + 18'(j);
`ifdef FIFO_FWFT_EN
            checks++; if (data_out !== exp_d) begin errors++; $display("FAIL b2b_head[%0d] got=%h exp=%h", j, data_out, exp_d); end
`endif
            tick();
`ifndef FIFO_FWFT_EN
            checks++; if (data_out !== exp_d) begin errors++; $display("FAIL b2b_dout[%0d] got=%h exp=%h", j, data_out, exp_d); end
`endif
            checks++; if (count !== 5'd16 || full !== 1'b1) begin
                errors++; $display("FAIL b2b_level[%0d] count=%0d full=%b exp 16/1", j, count, full); end
        end
        wr = 1'b0; rd = 1'b0;
        checks++; if ({overflow, underflow} !== 2'b00) begin
            errors++; $display("FAIL b2b_errs got=%b exp=00", {overflow, underflow}); end
    endtask

    // Test 6: asynchronous reset with count=7 clears before the next edge.
    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wr = 1'b1; data_in = 18'(i);
            tick();
        end
        checks++; if (count !== 5'd7) begin errors++; $display("FAIL ar_pre got=%0d exp=7", count); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL ar_async count=%0d empty=%b exp 0/1", count, empty); end
        tick();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL ar_hold got=%0d exp=0", count); end
        wr = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_empty_wr_rd();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
